// File: rtl/jtpopeye_obj_dma.sv
// Popeye sprite DMA: on the start of vertical blank, takes the Z80 bus and
// copies DMA_LEN bytes from CPU RAM at SRC_BASE into object RAM.
module jtpopeye_obj_dma #(
  parameter logic [15:0] SRC_BASE = 16'h8C00,
  parameter logic [9:0]  DMA_LEN  = 10'd640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        VB_n,
  input  logic        dma_en,
  input  logic        busak_n,
  input  logic [7:0]  cpu_din,
  output logic        busrq_n,
  output logic [15:0] cpu_addr,
  output logic        cpu_rd,
  output logic [9:0]  obj_addr,
  output logic [7:0]  obj_dout,
  output logic        obj_we,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_READ     = 3'd3,
    ST_WRITE    = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [9:0]  count_r;
  logic [9:0]  count_nxt_s;
  logic [10:0] count_inc_s;
  logic        vb_last_r;
  logic        vb_fall_s;

  // Next-state and byte counter; VB_n high means blank has ended.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    count_inc_s = {1'b0, count_r} + 11'd1;
    vb_fall_s   = vb_last_r & ~VB_n;
    case (state_r)
      ST_IDLE: begin
        if (vb_fall_s && dma_en) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (VB_n) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (VB_n) begin
          state_nxt_s = ST_RELEASE;
        end else if (!busak_n) begin
          state_nxt_s = ST_READ;
          count_nxt_s = 10'd0;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_READ: begin
        state_nxt_s = ST_WRITE;
      end
      ST_WRITE: begin
        count_nxt_s = count_inc_s[9:0];
        // An end of blank mid-byte lets this write land, then gives the bus back.
        if ((count_inc_s < {1'b0, DMA_LEN}) && !VB_n) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = 10'd0;
      end
    endcase
  end

  // State, edge detector and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      count_r   <= 10'd0;
      vb_last_r <= 1'b1;
      busrq_n   <= 1'b1;
      busy      <= 1'b0;
      cpu_rd    <= 1'b0;
      cpu_addr  <= SRC_BASE;
      obj_we    <= 1'b0;
      obj_addr  <= 10'd0;
      obj_dout  <= 8'd0;
    end else if (cen) begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      vb_last_r <= VB_n;
      busrq_n   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_RELEASE);
      busy      <= (state_nxt_s != ST_IDLE);
      cpu_rd    <= (state_nxt_s == ST_READ);
      obj_we    <= (state_nxt_s == ST_WRITE);
      if (state_nxt_s == ST_READ) begin
        cpu_addr <= SRC_BASE + {6'd0, count_nxt_s};
      end
      if (state_nxt_s == ST_WRITE) begin
        obj_addr <= count_r;
        obj_dout <= cpu_din;
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
// Scoreboard bench for jtpopeye_obj_dma: expected object-RAM writes are queued
// from a plain memory model and popped by an independent output monitor.
module tb_jtpopeye_obj_dma;

  localparam logic [15:0] SRC_BASE = 16'h8C00;
  localparam int          N        = 640;
  localparam int          BUDGET   = 20000;

  logic        clk = 1'b0;
  logic        rst_n, cen, VB_n, dma_en, busak_n;
  logic [7:0]  cpu_din;
  logic        busrq_n, cpu_rd, obj_we, busy;
  logic [15:0] cpu_addr;
  logic [9:0]  obj_addr;
  logic [7:0]  obj_dout;

  logic [7:0] mem [0:65535];
  assign cpu_din = mem[cpu_addr];

  jtpopeye_obj_dma #(.SRC_BASE(SRC_BASE), .DMA_LEN(10'd640)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .VB_n(VB_n), .dma_en(dma_en),
    .busak_n(busak_n), .cpu_din(cpu_din), .busrq_n(busrq_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .obj_addr(obj_addr),
    .obj_dout(obj_dout), .obj_we(obj_we), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  oa;
    logic [7:0]  d;
    logic [15:0] ca;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  opt_wr;
  logic opt_valid = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cen_mode = 0;
  int   last_wr_addr = -1;
  int   wr_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not reached at %0t", name, $time);
  endtask

  // Reference: byte i of a frame goes from CPU address SRC_BASE+i (mod 64K) to object address i.
  function automatic wr_t model_byte(input int i);
    wr_t w;
    w.oa = i[9:0];
    w.ca = SRC_BASE + i[15:0];
    w.d  = mem[w.ca];
    return w;
  endfunction

  task automatic fill_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
  endtask

  task automatic push_bytes(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(model_byte(i));
  endtask

  // cen generator: always on, one clk in three, or random
  initial begin
    int phase;
    phase = 0;
    cen = 1'b1;
    forever begin
      @(negedge clk);
      case (cen_mode)
        0: cen = 1'b1;
        1: begin phase = (phase + 1) % 3; cen = (phase == 0); end
        default: cen = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every write and checks outputs hold when cen=0.
  initial begin
    logic [37:0] prev, cur;
    logic        have_prev, prev_we, c, r;
    logic [15:0] rd_addr;
    wr_t         e;
    have_prev = 1'b0;
    prev_we   = 1'b0;
    rd_addr   = 16'h0000;
    prev      = '0;
    forever begin
      @(posedge clk);
      c = cen;
      r = rst_n;
      #1;
      if (!r) begin
        exp_q.delete();
        opt_valid = 1'b0;
        have_prev = 1'b0;
        prev_we   = 1'b0;
      end else begin
        cur = {busrq_n, cpu_addr, cpu_rd, obj_addr, obj_dout, obj_we, busy};
        if (!c) begin
          if (have_prev) check("hold_no_cen", 64'(cur), 64'(prev));
        end else begin
          if (obj_we) begin
            check("we_one_cen", 64'(prev_we), 64'd0);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("obj_addr", 64'(obj_addr), 64'(e.oa));
              check("obj_dout", 64'(obj_dout), 64'(e.d));
              check("cpu_addr", 64'(rd_addr), 64'(e.ca));
            end else if (opt_valid) begin
              check("opt_obj_addr", 64'(obj_addr), 64'(opt_wr.oa));
              check("opt_obj_dout", 64'(obj_dout), 64'(opt_wr.d));
              opt_valid = 1'b0;
            end else begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_write: got obj_addr %0h expected no write at %0t", obj_addr, $time);
            end
            last_wr_addr = int'(obj_addr);
            wr_count++;
          end
          if (cpu_rd) rd_addr = cpu_addr;
          prev_we = obj_we;
        end
        prev = cur;
        have_prev = 1'b1;
      end
    end
  end

  task automatic wait_cen(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (cen) k++;
    end
    #1;
  endtask

  task automatic count_to_release(output int n);
    int t;
    n = 0;
    t = 0;
    while (t < BUDGET) begin
      @(posedge clk);
      if (cen) n++;
      #1;
      t++;
      if (busrq_n) break;
    end
    if (!busrq_n) fail("release_timeout");
  endtask

  task automatic wait_wr_addr(input int a);
    int t;
    t = 0;
    while (last_wr_addr != a && t < BUDGET) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (last_wr_addr != a) fail("write_addr_timeout");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < BUDGET) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) fail("idle_timeout");
  endtask

  task automatic frame_start(input int ack_dly);
    @(negedge clk);
    VB_n = 1'b1; dma_en = 1'b1; busak_n = 1'b1;
    wait_cen(3);
    last_wr_addr = -1;
    @(negedge clk);
    VB_n = 1'b0;
    wait_cen(ack_dly);
    check("busrq_asserted", 64'(busrq_n), 64'd0);
    @(negedge clk);
    busak_n = 1'b0;
  endtask

  // Full frame: 2*N cen cycles of transfer after the acknowledge is sampled.
  task automatic full_frame(input int ack_dly, input bit flip_en);
    int n;
    push_bytes(0, N - 1);
    frame_start(ack_dly);
    if (flip_en) dma_en = 1'b0;
    count_to_release(n);
    check("release_cycles", 64'(n), 64'(2 * N + 1));
    @(negedge clk);
    busak_n = 1'b1; VB_n = 1'b1; dma_en = 1'b1;
    wait_cen(2);
    check("busy_after_frame", 64'(busy), 64'd0);
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n, w0;
    fill_mem();
    rst_n = 1'b0; VB_n = 1'b1; dma_en = 1'b0; busak_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_busrq_n", 64'(busrq_n), 64'd1);
    check("rst_cpu_rd", 64'(cpu_rd), 64'd0);
    check("rst_obj_we", 64'(obj_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cpu_addr", 64'(cpu_addr), 64'(SRC_BASE));
    check("rst_obj_addr", 64'(obj_addr), 64'd0);
    check("rst_obj_dout", 64'(obj_dout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // nominal, acknowledge two cen cycles after the edge
    full_frame(2, 1'b0);

    // disabled: no request at all
    @(negedge clk);
    dma_en = 1'b0;
    wait_cen(3);
    @(negedge clk);
    VB_n = 1'b0;
    wait_cen(10);
    check("dis_busrq_n", 64'(busrq_n), 64'd1);
    check("dis_busy", 64'(busy), 64'd0);
    @(negedge clk);
    VB_n = 1'b1;
    wait_cen(3);

    // no acknowledge, then blank ends
    w0 = wr_count;
    @(negedge clk);
    dma_en = 1'b1;
    @(negedge clk);
    VB_n = 1'b0;
    wait_cen(5);
    check("noack_busrq_n", 64'(busrq_n), 64'd0);
    check("noack_busy", 64'(busy), 64'd1);
    @(negedge clk);
    VB_n = 1'b1;
    count_to_release(n);
    check("noack_release_cens", 64'(n), 64'd1);
    wait_cen(1);
    check("noack_idle", 64'(busy), 64'd0);
    check("noack_writes", 64'(wr_count - w0), 64'd0);

    // early end of blank after byte 100
    push_bytes(0, 100);
    opt_wr = model_byte(101);
    opt_valid = 1'b1;
    frame_start(3);
    wait_wr_addr(100);
    @(negedge clk);
    VB_n = 1'b1;
    wait_idle();
    check("early_writes_seen", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    busak_n = 1'b1;
    opt_valid = 1'b0;
    wait_cen(3);

    // reset during byte 300, then a clean frame from address 0
    push_bytes(0, N - 1);
    frame_start(2);
    wait_wr_addr(300);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busrq_n", 64'(busrq_n), 64'd1);
    check("midrst_obj_we", 64'(obj_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; busak_n = 1'b1; VB_n = 1'b1;
    full_frame(2, 1'b0);

    // cen one clk in three
    cen_mode = 1;
    fill_mem();
    full_frame(2, 1'b0);

    // random cen, random acknowledge delay, dma_en dropped mid-transfer
    cen_mode = 2;
    for (int f = 0; f < 2; f++) begin
      fill_mem();
      full_frame($urandom_range(2, 6), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtpopeye_obj_dma.md
JTPOPEYE_OBJ_DMA -- requirements
Module: jtpopeye_obj_dma

Interface
REQ-001 Parameter: SRC_BASE, 16'h8C00, CPU address of the first sprite byte.
REQ-002 Parameter: DMA_LEN, 10'd640, number of bytes copied per frame, legal range 1..1023.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: cen  input  1  clock enable; the FSM advances only on clk edges with cen=1.
REQ-006 Port: VB_n  input  1  vertical blank, active-low.
REQ-007 Port: dma_en  input  1  CPU DMA-enable latch bit (DM10).
REQ-008 Port: busak_n  input  1  Z80 bus acknowledge, active-low.
REQ-009 Port: cpu_din  input  8  CPU RAM read data, valid one cen cycle after cpu_addr is driven.
REQ-010 Port: busrq_n  output  1  Z80 bus request, active-low.
REQ-011 Port: cpu_addr  output  16  CPU RAM read address during DMA.
REQ-012 Port: cpu_rd  output  1  CPU RAM read strobe.
REQ-013 Port: obj_addr  output  10  object RAM write address.
REQ-014 Port: obj_dout  output  8  object RAM write data.
REQ-015 Port: obj_we  output  1  object RAM write enable, one cen cycle wide.
REQ-016 Port: busy  output  1  high from bus request until bus release.

Function
REQ-017 The block SHALL detect VB_n falling edges by registering VB_n on cen cycles only.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT_ACK, READ, WRITE and RELEASE.
REQ-019 IDLE->REQ SHALL occur on a detected VB_n falling edge with dma_en=1; otherwise the FSM SHALL stay in IDLE.
REQ-020 REQ SHALL drive busrq_n=0 and SHALL move to WAIT_ACK on the next cen.
REQ-021 WAIT_ACK SHALL hold busrq_n=0 until busak_n=0 is sampled on a cen, then go to READ with the byte counter at 0.
REQ-022 READ SHALL drive cpu_addr=SRC_BASE+count and cpu_rd=1, then go to WRITE on the next cen.
REQ-023 WRITE SHALL set obj_dout=cpu_din, obj_addr=count and obj_we=1 for exactly one cen cycle.
REQ-024 In WRITE, count SHALL increment; the FSM SHALL go to READ if count+1<DMA_LEN, else to RELEASE.
REQ-025 Each byte SHALL take 2 cen cycles; a full transfer SHALL take 2*DMA_LEN cen cycles after acknowledge.
REQ-026 Address arithmetic SHALL be 16-bit modulo, with wrap-around at 16'hFFFF allowed.
REQ-027 RELEASE SHALL drive busrq_n=1 and cpu_rd=0, and SHALL return to IDLE on the next cen.
REQ-028 VB_n rising in REQ or WAIT_ACK SHALL abort the request and go to RELEASE with no write.
REQ-029 VB_n rising in READ or WRITE SHALL let the current byte finish its write, then go to RELEASE.
REQ-030 A dma_en change after IDLE SHALL be ignored until the FSM returns to IDLE.
REQ-031 A new VB_n falling edge SHALL be ignored while the FSM is outside IDLE.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 Outputs SHALL hold their values on cycles with cen=0.

Reset
REQ-034 While rst_n=0, the FSM SHALL be forced to IDLE and count to 0.
REQ-035 Reset SHALL force busrq_n=1, cpu_rd=0, obj_we=0, busy=0, cpu_addr=SRC_BASE, obj_addr=0 and obj_dout=0.
REQ-036 Reset SHALL force the registered VB_n to 1, so that reset alone cannot create a falling edge.
REQ-037 A reset during a transfer SHALL release the bus within the same clk edge, with no further writes.

Verification
REQ-038 Scenario, nominal: dma_en=1, VB_n falls, busak_n=0 two cen cycles later -> 640 writes, obj_addr 0..639, cpu_addr 8C00..8E7F, busrq_n=1 after 1280 cen cycles.
REQ-039 Scenario, disabled: dma_en=0, VB_n falls -> busrq_n stays 1, no obj_we pulse, busy=0.
REQ-040 Scenario, no acknowledge: busak_n held at 1, then VB_n rises -> busrq_n returns to 1 on the next cen, zero writes.
REQ-041 Scenario, early end of blank: VB_n rises after the write of byte 100 -> the last write has obj_addr=100 or 101, then RELEASE.
REQ-042 Scenario, reset mid-copy: rst_n=0 during byte 300 -> busrq_n=1 and obj_we=0 on the next clk; the next frame restarts at obj_addr 0.
REQ-043 Scenario, cen gating: cen=1 on one clk in three -> write sequence and data identical to the nominal scenario, with obj_we lasting one cen period.
